// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: hex font, segment bit
// positions and the output polarity helper.
package seven_seg_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam int unsigned SEG_W  = 8;
  localparam int unsigned FONT_W = 7;

  // Active-high patterns, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [FONT_W-1:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Converts an active-high pattern into pin levels.
  function automatic logic [SEG_W-1:0] apply_polarity(input logic [SEG_W-1:0] pattern,
                                                      input logic             active_low);
    return active_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to seven-segment decoder (active-high, g..a).
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]        nibble_i,
  output logic [FONT_W-1:0] pattern_c_o
);

  assign pattern_c_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment driver: scan divider, frame shadowing,
// leading-zero blanking, PWM brightness and configurable pin polarity.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS             = 4,
  parameter int unsigned SCAN_DIVIDE_LOG2   = 17,
  parameter int unsigned BRIGHTNESS_BITS    = 4,
  parameter int unsigned SEGMENT_ACTIVE_LOW = 1,
  parameter int unsigned DIGIT_ACTIVE_LOW   = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [4*DIGITS-1:0]        data_i,
  input  logic [DIGITS-1:0]          decimal_point_i,
  input  logic                       blank_leading_zeros_i,
  input  logic [BRIGHTNESS_BITS-1:0] brightness_i,
  input  logic                       enable_i,
  output logic [SEG_W-1:0]           segment_o,
  output logic [DIGITS-1:0]          digit_o,
  output logic                       frame_start_o
);

  localparam int unsigned DATA_W = 4 * DIGITS;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SLOT_W = SCAN_DIVIDE_LOG2;
  localparam int unsigned BRT_W  = BRIGHTNESS_BITS;

  localparam logic              SEG_AL  = (SEGMENT_ACTIVE_LOW != 0);
  localparam logic              DIG_AL  = (DIGIT_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]  SEG_OFF = apply_polarity(8'h00, SEG_AL);
  localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_AL}};

  if (SCAN_DIVIDE_LOG2 < BRIGHTNESS_BITS || DIGITS < 1 || BRIGHTNESS_BITS < 1) begin : g_bad_params
    $error("seven_seg_scanner: illegal parameter combination");
  end

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DIGITS-1:0] dp_q, dp_d;
  logic              blz_q, blz_d;
  logic [SEG_W-1:0]  segment_q, segment_d;
  logic [DIGITS-1:0] digit_q, digit_d;
  logic              frame_start_q, frame_start_d;

  logic              frame_load_c;
  logic [3:0]        nibble_c;
  logic              dp_sel_c;
  logic              blank_c;
  logic              zero_run_c;
  logic [FONT_W-1:0] font_c;
  logic              pwm_lit_c;
  logic              active_c;
  logic [SEG_W-1:0]  seg_pattern_c;
  logic [DIGITS-1:0] digit_sel_c;

  // Slot counter and digit index; a frame starts whenever both are zero.
  always_comb begin
    slot_d       = slot_q + SLOT_W'(1);
    idx_d        = idx_q;
    frame_load_c = (slot_q == '0) && (idx_q == '0);
    if (&slot_q) begin
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Shadow capture; the loading cycle already displays the new values.
  always_comb begin
    data_d        = data_q;
    dp_d          = dp_q;
    blz_d         = blz_q;
    frame_start_d = frame_load_c;
    if (frame_load_c) begin
      data_d = data_i;
      dp_d   = decimal_point_i;
      blz_d  = blank_leading_zeros_i;
    end
  end

  // Nibble/DP of the scanned digit and its leading-zero blank flag.
  always_comb begin
    nibble_c   = 4'h0;
    dp_sel_c   = 1'b0;
    blank_c    = 1'b0;
    zero_run_c = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c && (data_d[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nibble_c = data_d[4*i +: 4];
        dp_sel_c = dp_d[i];
        blank_c  = (i != 0) && blz_d && zero_run_c;
      end
    end
  end

  hex_to_seven_seg u_decoder (
    .nibble_i    (nibble_c),
    .pattern_c_o (font_c)
  );

  // PWM gate, pattern assembly and polarity.
  always_comb begin
    pwm_lit_c     = (slot_q[SLOT_W-1 -: BRT_W] <= brightness_i);
    active_c      = enable_i && pwm_lit_c;
    seg_pattern_c = '0;
    if (!blank_c) begin
      seg_pattern_c[SEG_DP]      = dp_sel_c;
      seg_pattern_c[SEG_G:SEG_A] = font_c;
    end
    digit_sel_c = DIGITS'(1) << idx_q;
    segment_d   = SEG_OFF;
    digit_d     = DIG_OFF;
    if (active_c) begin
      segment_d = apply_polarity(seg_pattern_c, SEG_AL);
      digit_d   = digit_sel_c ^ DIG_OFF;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q        <= '0;
      idx_q         <= '0;
      data_q        <= '0;
      dp_q          <= '0;
      blz_q         <= 1'b0;
      segment_q     <= SEG_OFF;
      digit_q       <= DIG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      idx_q         <= idx_d;
      data_q        <= data_d;
      dp_q          <= dp_d;
      blz_q         <= blz_d;
      segment_q     <= segment_d;
      digit_q       <= digit_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign segment_o     = segment_q;
  assign digit_o       = digit_q;
  assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: cycle model plus directed literals.
module tb_seven_seg_scanner;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SCAN   = 4;
  localparam int unsigned BB     = 2;
  localparam int          SLOT   = 1 << SCAN;
  localparam int          FRAME  = SLOT * DIGITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        blz = 1'b0;
  logic [1:0]  brt = 2'd3;
  logic        en = 1'b1;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        fs;

  int checks = 0;
  int failures = 0;

  seven_seg_scanner #(
    .DIGITS             (DIGITS),
    .SCAN_DIVIDE_LOG2   (SCAN),
    .BRIGHTNESS_BITS    (BB),
    .SEGMENT_ACTIVE_LOW (1),
    .DIGIT_ACTIVE_LOW   (1)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .data_i                (data),
    .decimal_point_i       (dp),
    .blank_leading_zeros_i (blz),
    .brightness_i          (brt),
    .enable_i              (en),
    .segment_o             (seg),
    .digit_o               (dig),
    .frame_start_o         (fs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: outputs after each edge follow from elapsed cycles since reset.
  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_t = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_data = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic        m_blz = 1'b0;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_fs;

  always begin
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_valid = 1'b1;
      m_data = 16'h0; m_dp = 4'h0; m_blz = 1'b0;
      e_seg = 8'hFF; e_dig = 4'hF; e_fs = 1'b0;
    end else if (m_valid) begin
      int slot, idx;
      logic [3:0] nib;
      logic blank;
      slot = m_t % SLOT;
      idx  = (m_t / SLOT) % DIGITS;
      e_fs = (m_t % FRAME == 0);
      if (e_fs) begin
        m_data = data; m_dp = dp; m_blz = blz;
      end
      if (en && (slot / (SLOT / 4)) <= int'(brt)) begin
        nib   = 4'((m_data >> (4 * idx)) & 16'hF);
        blank = m_blz && idx > 0 && ((m_data >> (4 * idx)) == 16'h0);
        e_seg = blank ? 8'hFF : ~{m_dp[idx], font[nib]};
        e_dig = ~(4'b0001 << idx);
      end else begin
        e_seg = 8'hFF; e_dig = 4'hF;
      end
      m_t++;
    end
    #1;
    if (m_valid) begin
      check("model_segment", 32'(seg), 32'(e_seg));
      check("model_digit", 32'(dig), 32'(e_dig));
      check("model_frame_start", 32'(fs), 32'(e_fs));
    end
  end

  task automatic wait_frame(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs !== 1'b1 && n < 200);
    check(name, 32'(fs), 32'd1);
  endtask

  task automatic find_digit(input logic [3:0] sel, input logic [7:0] seg_exp, input string name);
    int n = 0;
    while (dig !== sel && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_sel"}, 32'(dig), 32'(sel));
    check(name, 32'(seg), 32'(seg_exp));
  endtask

  initial begin
    int cnt, cnt_fs, bad;
    data = 16'h12AF; brt = 2'd3; en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg), 32'hFF);
    check("reset_dig", 32'(dig), 32'hF);
    check("reset_fs", 32'(fs), 32'h0);
    rst = 1'b0;

    // Scan order and first-frame timing.
    @(negedge clk);
    check("scan_fs_first", 32'(fs), 32'h1);
    check("scan_d0_sel", 32'(dig), 32'hE);
    check("scan_d0_seg", 32'(seg), 32'h8E);
    repeat (16) @(negedge clk);
    check("scan_d1_sel", 32'(dig), 32'hD);
    check("scan_d1_seg", 32'(seg), 32'h88);
    repeat (32) @(negedge clk);
    check("scan_d3_sel", 32'(dig), 32'h7);
    check("scan_d3_seg", 32'(seg), 32'hF9);
    repeat (15) @(negedge clk);
    check("scan_fs_63", 32'(fs), 32'h0);
    @(negedge clk);
    check("scan_fs_64", 32'(fs), 32'h1);

    // Brightness duty.
    brt = 2'd0; cnt = 0;
    repeat (FRAME) begin @(negedge clk); if (dig != 4'hF) cnt++; end
    check("brt0_lit_cycles", 32'(cnt), 32'd16);
    brt = 2'd2; cnt = 0;
    repeat (FRAME) begin @(negedge clk); if (dig != 4'hF) cnt++; end
    check("brt2_lit_cycles", 32'(cnt), 32'd48);
    brt = 2'd3;

    // Leading-zero blanking.
    data = 16'h0050; blz = 1'b1;
    wait_frame("lz_frame");
    find_digit(4'hD, 8'h92, "lz_d1");
    find_digit(4'hB, 8'hFF, "lz_d2");
    find_digit(4'h7, 8'hFF, "lz_d3");
    blz = 1'b0;
    wait_frame("nolz_frame");
    find_digit(4'h7, 8'hC0, "nolz_d3");
    data = 16'h0000; blz = 1'b1;
    wait_frame("zero_frame");
    find_digit(4'hE, 8'hC0, "zero_d0");
    find_digit(4'hD, 8'hFF, "zero_d1");
    blz = 1'b0;

    // Shadowing: mid-frame data change is deferred.
    data = 16'h1111;
    wait_frame("shadow_frame");
    find_digit(4'hD, 8'hF9, "shadow_d1");
    data = 16'h2222;
    find_digit(4'hB, 8'hF9, "shadow_d2_old");
    find_digit(4'h7, 8'hF9, "shadow_d3_old");
    wait_frame("shadow_frame2");
    find_digit(4'hE, 8'hA4, "shadow_d0_new");
    find_digit(4'hD, 8'hA4, "shadow_d1_new");

    // Decimal points.
    data = 16'h12AF; dp = 4'b0100;
    wait_frame("dp_frame");
    find_digit(4'hD, 8'h88, "dp_d1_off");
    find_digit(4'hB, 8'h24, "dp_d2_on");
    find_digit(4'h7, 8'hF9, "dp_d3_off");
    dp = 4'h0;

    // Enable low blanks outputs but frames continue.
    en = 1'b0; cnt_fs = 0; bad = 0;
    repeat (FRAME) begin
      @(negedge clk);
      if (fs) cnt_fs++;
      if (dig != 4'hF || seg != 8'hFF) bad++;
    end
    check("en0_active_cycles", 32'(bad), 32'd0);
    check("en0_frame_pulses", 32'(cnt_fs), 32'd1);
    en = 1'b1;

    // Reset mid-frame.
    wait_frame("rst_frame");
    find_digit(4'hB, 8'hA4, "rst_pre_d2");
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_seg", 32'(seg), 32'hFF);
    check("rst_mid_dig", 32'(dig), 32'hF);
    check("rst_mid_fs", 32'(fs), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_fs", 32'(fs), 32'h1);
    check("rst_rel_dig", 32'(dig), 32'hE);
    check("rst_rel_seg", 32'(seg), 32'h8E);
    repeat (16) @(negedge clk);
    check("rst_rel_d1", 32'(dig), 32'hD);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
